approx_mul_ha_pipe: RTL and testbench



---
 rtl/approx_mul_ha_pipe_if.sv | 25 ++
 rtl/approx_mul_ha_pipe.sv | 150 +++++++++++++++
 tb/tb_approx_mul_ha_pipe.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_mul_ha_pipe_if.sv
// Streaming bus for the approximate multiplier.
// The master side drives operands and accepts products; the slave side is the multiplier.
interface approx_mul_ha_pipe_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic                   approx;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     p;
    logic                   out_approx;

    modport master (
        output in_valid, x, y, approx, out_ready,
        input  in_ready, out_valid, p, out_approx
    );

    modport slave (
        input  in_valid, x, y, approx, out_ready,
        output in_ready, out_valid, p, out_approx
    );
endinterface

// File: rtl/approx_mul_ha_pipe.sv
// Pipelined unsigned approximate multiplier.
// S1 captures operands, S2 holds the half-adder-compressed row pairs
// (sum and carry vectors per pair), S3 holds the exact sum of those rows.
// In approximate mode, columns below APPROX_COLS use OR instead of a half adder,
// which drops the carry, so the result never exceeds the exact product.
module approx_mul_ha_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    approx_mul_ha_pipe_if.slave  bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     approx_cnt
);
    localparam int PW    = 2 * WIDTH;
    localparam int PAIRS = WIDTH / 2;

    logic                  adv;
    logic                  accept;

    logic                  s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]      s1_x_q, s1_x_d;
    logic [WIDTH-1:0]      s1_y_q, s1_y_d;
    logic                  s1_approx_q, s1_approx_d;

    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_approx_q, s2_approx_d;
    logic [PAIRS*PW-1:0]   s2_sum_q, s2_sum_d;
    logic [PAIRS*PW-1:0]   s2_carry_q, s2_carry_d;

    logic                  s3_valid_q, s3_valid_d;
    logic [PW-1:0]         p_q, p_d;
    logic                  out_approx_q, out_approx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [PAIRS*PW-1:0]   pair_sum_w;
    logic [PAIRS*PW-1:0]   pair_carry_w;
    logic [PW-1:0]         row_total;

    // One half-adder row per pair of partial-product rows (2k, 2k+1).
    for (genvar gi = 0; gi < PAIRS; gi++) begin : g_pair
        logic [PW-1:0] sum_v;
        logic [PW-1:0] carry_v;

        // Compress the overlap columns; the two end bits pass straight through.
        always_comb begin
            sum_v   = '0;
            carry_v = '0;
            sum_v[2*gi]       = s1_y_q[0] & s1_x_q[2*gi];
            sum_v[2*gi+WIDTH] = s1_y_q[WIDTH-1] & s1_x_q[2*gi+1];
            for (int j = 1; j < WIDTH; j++) begin
                if (s1_approx_q && ((2*gi + j) < APPROX_COLS)) begin
                    sum_v[2*gi+j] = (s1_y_q[j] & s1_x_q[2*gi]) | (s1_y_q[j-1] & s1_x_q[2*gi+1]);
                end else begin
                    sum_v[2*gi+j]     = (s1_y_q[j] & s1_x_q[2*gi]) ^ (s1_y_q[j-1] & s1_x_q[2*gi+1]);
                    carry_v[2*gi+j+1] = (s1_y_q[j] & s1_x_q[2*gi]) & (s1_y_q[j-1] & s1_x_q[2*gi+1]);
                end
            end
        end

        assign pair_sum_w[gi*PW +: PW]   = sum_v;
        assign pair_carry_w[gi*PW +: PW] = carry_v;
    end

    // Pipeline advance, final row summation and counter next-state.
    always_comb begin
        adv          = !s3_valid_q || bus.out_ready;
        accept       = bus.in_valid && adv;
        s1_valid_d   = s1_valid_q;
        s1_x_d       = s1_x_q;
        s1_y_d       = s1_y_q;
        s1_approx_d  = s1_approx_q;
        s2_valid_d   = s2_valid_q;
        s2_approx_d  = s2_approx_q;
        s2_sum_d     = s2_sum_q;
        s2_carry_d   = s2_carry_q;
        s3_valid_d   = s3_valid_q;
        p_d          = p_q;
        out_approx_d = out_approx_q;
        cnt_d        = cnt_q;

        row_total = '0;
        for (int k = 0; k < PAIRS; k++) begin
            row_total = row_total + s2_sum_q[k*PW +: PW] + s2_carry_q[k*PW +: PW];
        end

        if (adv) begin
            s1_valid_d  = bus.in_valid;
            s1_x_d      = bus.x;
            s1_y_d      = bus.y;
            s1_approx_d = bus.approx;
            s2_valid_d  = s1_valid_q;
            s2_approx_d = s1_approx_q;
            s2_sum_d    = pair_sum_w;
            s2_carry_d  = pair_carry_w;
            s3_valid_d  = s2_valid_q;
            // Only real transactions update p, so bubbles leave the last product visible.
            if (s2_valid_q) begin
                p_d          = row_total;
                out_approx_d = s2_approx_q;
            end
        end

        // Clear takes priority over a same-cycle increment.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && bus.approx && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_approx_q  <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_approx_q  <= 1'b0;
            s2_sum_q     <= '0;
            s2_carry_q   <= '0;
            s3_valid_q   <= 1'b0;
            p_q          <= '0;
            out_approx_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            s1_approx_q  <= s1_approx_d;
            s2_valid_q   <= s2_valid_d;
            s2_approx_q  <= s2_approx_d;
            s2_sum_q     <= s2_sum_d;
            s2_carry_q   <= s2_carry_d;
            s3_valid_q   <= s3_valid_d;
            p_q          <= p_d;
            out_approx_q <= out_approx_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.in_ready   = adv;
    assign bus.out_valid  = s3_valid_q;
    assign bus.p          = p_q;
    assign bus.out_approx = out_approx_q;
    assign approx_cnt     = cnt_q;
endmodule

// File: tb/tb_approx_mul_ha_pipe.sv
// Self-checking bench for approx_mul_ha_pipe (WIDTH=8, APPROX_COLS=4, CNT_W=16).
module tb_approx_mul_ha_pipe;
    localparam int W  = 8;
    localparam int AC = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] approx_cnt;

    approx_mul_ha_pipe_if #(.WIDTH(W)) bus ();

    approx_mul_ha_pipe #(.WIDTH(W), .APPROX_COLS(AC), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .approx_cnt (approx_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] p;
        logic           ap;
        int             acc;
        bit             lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    int   stall_lo = 0;
    int   stall_hi = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact product minus 2^c for every OR column where both inputs are 1.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] mx, input logic [W-1:0] my,
                                             input logic ap);
        int r;
        r = int'(mx) * int'(my);
        if (ap) begin
            for (int k = 0; k < W/2; k++) begin
                for (int c = 2*k+1; c <= 2*k+W-1; c++) begin
                    if (c < AC && my[c-2*k] && mx[2*k] && my[c-2*k-1] && mx[2*k+1])
                        r = r - (1 << c);
                end
            end
        end
        return r[2*W-1:0];
    endfunction

    task automatic update_ready();
        bus.out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            update_ready();
            @(posedge clk);
            #1;
        end
    endtask

    // Present one transaction and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] sx, input logic [W-1:0] sy, input logic ap,
                        input logic [2*W-1:0] ep, input bit push, input bit lat);
        bit acc;
        int ac_c;
        int n;
        acc = 0; n = 0; ac_c = 0;
        bus.in_valid = 1'b1;
        bus.x = sx;
        bus.y = sy;
        bus.approx = ap;
        while (!acc && n < 50) begin
            update_ready();
            @(negedge clk);
            acc = bus.in_ready;
            ac_c = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL send_timeout got in_ready=0 for %0d cycles want accept", n);
        end
        if (acc) begin
            if (push) sb.push_back('{p: ep, ap: ap, acc: ac_c, lat: lat});
            if (cnt_clr) exp_cnt = 0;
            else if (ap && exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            wait_cycles(1);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain got %0d outstanding want 0", sb.size());
        end
    endtask

    task automatic check_cnt(input string tag);
        checks++;
        assert (approx_cnt === CW'(exp_cnt)) else begin
            errors++;
            $error("FAIL %s got approx_cnt=%0d want %0d", tag, approx_cnt, exp_cnt);
        end
    endtask

    // Output monitor: pops the scoreboard on each handshake, checks hold behaviour during stalls.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output got p=%0d want no output", bus.p);
            end
            if (sb.size() != 0) begin
                if (bus.out_ready) begin
                    mon_e = sb.pop_front();
                    $display("tx p=%0d approx=%0d expected p=%0d", bus.p, bus.out_approx, mon_e.p);
                    checks++;
                    assert (bus.p === mon_e.p) else begin
                        errors++;
                        $error("FAIL product got %0d want %0d", bus.p, mon_e.p);
                    end
                    checks++;
                    assert (bus.out_approx === mon_e.ap) else begin
                        errors++;
                        $error("FAIL out_approx got %0d want %0d", bus.out_approx, mon_e.ap);
                    end
                    if (mon_e.lat) begin
                        checks++;
                        assert (cyc - mon_e.acc === 3) else begin
                            errors++;
                            $error("FAIL latency got %0d want 3", cyc - mon_e.acc);
                        end
                    end
                end else begin
                    checks++;
                    assert (bus.p === sb[0].p) else begin
                        errors++;
                        $error("FAIL stall_hold got p=%0d want %0d", bus.p, sb[0].p);
                    end
                    checks++;
                    assert (bus.in_ready === 1'b0) else begin
                        errors++;
                        $error("FAIL stall_in_ready got %0d want 0", bus.in_ready);
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic         ra;
        int           s0;

        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.y         = '0;
        bus.approx    = 1'b0;
        bus.out_ready = 1'b1;

        // Reset and reset-state checks.
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
        checks++;
        assert (bus.out_valid === 1'b0) else begin
            errors++; $error("FAIL rst_out_valid got %0d want 0", bus.out_valid);
        end
        checks++;
        assert (bus.p === '0) else begin
            errors++; $error("FAIL rst_p got %0d want 0", bus.p);
        end
        checks++;
        assert (bus.out_approx === 1'b0) else begin
            errors++; $error("FAIL rst_out_approx got %0d want 0", bus.out_approx);
        end
        checks++;
        assert (bus.in_ready === 1'b1) else begin
            errors++; $error("FAIL rst_in_ready got %0d want 1", bus.in_ready);
        end
        check_cnt("rst_cnt");

        // Directed products with latency check.
        send(8'd255, 8'd255, 1'b0, 16'd65025, 1, 1);
        drain();
        send(8'd255, 8'd255, 1'b1, 16'd65003, 1, 1);
        drain();
        exp_cnt = 0;
        cnt_clr = 1'b1;
        wait_cycles(1);
        cnt_clr = 1'b0;
        check_cnt("cnt_cleared");
        send(8'd3, 8'd3, 1'b1, 16'd7, 1, 1);
        send(8'd3, 8'd1, 1'b1, 16'd3, 1, 1);
        drain();
        check_cnt("cnt_two");

        // Back-to-back random stream with a downstream stall.
        s0 = cyc;
        stall_lo = s0 + 4;
        stall_hi = s0 + 7;
        for (int i = 0; i < 10; i++) begin
            rx = W'($urandom_range(0, 255));
            ry = W'($urandom_range(0, 255));
            ra = 1'($urandom_range(0, 1));
            send(rx, ry, ra, model(rx, ry, ra), 1, 0);
        end
        drain();
        stall_lo = 0;
        stall_hi = -1;
        check_cnt("cnt_stream");

        // Reset with two transactions in flight: both are discarded.
        send(8'd200, 8'd100, 1'b1, 16'd0, 0, 0);
        send(8'd17, 8'd33, 1'b1, 16'd0, 0, 0);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            assert (bus.out_valid === 1'b0) else begin
                errors++; $error("FAIL rst_flush got out_valid=%0d want 0", bus.out_valid);
            end
            wait_cycles(1);
        end
        check_cnt("cnt_after_rst");

        // Counter saturation and clear-wins.
        for (int i = 0; i < 65534; i++) begin
            rx = W'($urandom_range(0, 255));
            ry = W'($urandom_range(0, 255));
            send(rx, ry, 1'b1, model(rx, ry, 1'b1), 1, 0);
        end
        check_cnt("cnt_preload");
        for (int i = 0; i < 3; i++) begin
            rx = W'($urandom_range(0, 255));
            ry = W'($urandom_range(0, 255));
            send(rx, ry, 1'b1, model(rx, ry, 1'b1), 1, 0);
            check_cnt("cnt_saturate");
        end
        cnt_clr = 1'b1;
        send(8'd3, 8'd3, 1'b1, 16'd7, 1, 0);
        cnt_clr = 1'b0;
        check_cnt("cnt_clr_wins");
        send(8'd12, 8'd10, 1'b1, model(8'd12, 8'd10, 1'b1), 1, 0);
        check_cnt("cnt_after_clr");
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
